// File: rtl/soc_coulomb_counter.sv
// Coulomb counter: integrates four float32 cell currents into Q0.32 SOC per cell.
// One shared converter / multiplier / packer is stepped serially over cells 0..3.
module soc_coulomb_counter #(
  parameter logic [15:0] GAIN     = 16'h0100,
  parameter logic [31:0] INIT_SOC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] i1,
  input  logic [31:0] i2,
  input  logic [31:0] i3,
  input  logic [31:0] i4,
  input  logic        load,
  input  logic [1:0]  load_cell,
  input  logic [31:0] load_soc,
  output logic [31:0] soc1,
  output logic [31:0] soc2,
  output logic [31:0] soc3,
  output logic [31:0] soc4,
  output logic        out_valid,
  output logic        err
);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_MAC, S_PACK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q;
  logic [31:0]        cur_q [4];
  logic signed [31:0] fix_q;
  logic               skip_q;
  logic [31:0]        soc_q [4];
  logic [31:0]        soc_out_q [4];
  logic               err_q;
  logic               accept;
  logic [31:0]        cur;
  logic signed [47:0] prod;
  logic signed [31:0] delta;
  logic [31:0]        soc_next;

  function automatic logic signed [31:0] float_to_fix(input logic [31:0] f);
    logic [7:0]  e;
    logic [23:0] m;
    logic [31:0] mag;
    e   = f[30:23];
    m   = {1'b1, f[22:0]};
    mag = '0;
    if (e == 8'd0 || e == 8'd255) mag = '0;
    else if (e >= 8'd142)         mag = 32'h7FFFFFFF;
    else if (e >= 8'd134)         mag = {8'd0, m} << (e - 8'd134);
    else if ((8'd134 - e) < 8'd24) mag = {8'd0, m} >> (8'd134 - e);
    return f[31] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] soc, input logic signed [31:0] d);
    logic signed [33:0] diff;
    diff = $signed({2'b00, soc}) - $signed({{2{d[31]}}, d});
    if (diff[33])      return '0;
    else if (diff[32]) return '1;
    else               return diff[31:0];
  endfunction

  function automatic logic [31:0] fix_to_float(input logic [31:0] q);
    int          p;
    logic [31:0] sh;
    logic [7:0]  e;
    logic [22:0] mant;
    p = 0;
    for (int i = 0; i < 32; i++) if (q[i]) p = i;
    sh   = q << (31 - p);
    e    = 8'(95 + p);
    mant = 23'((sh << 1) >> 9);
    return (q == '0) ? '0 : {1'b0, e, mant};
  endfunction

  assign in_ready  = (state_q == S_IDLE) && !load && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign err       = err_q;
  assign soc1      = soc_out_q[0];
  assign soc2      = soc_out_q[1];
  assign soc3      = soc_out_q[2];
  assign soc4      = soc_out_q[3];

  always_comb begin
    cur      = cur_q[idx_q];
    prod     = 48'(fix_q) * $signed({32'd0, GAIN});
    delta    = 32'(prod >>> 16);
    soc_next = sat_sub(soc_q[idx_q], delta);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CONV;
      S_CONV:  state_d = S_MAC;
      S_MAC:   state_d = S_PACK;
      S_PACK:  state_d = (idx_q == 2'd3) ? S_DONE : S_CONV;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) idx_q <= 2'd0;
      else if (state_q == S_PACK && idx_q != 2'd3) idx_q <= idx_q + 2'd1;
      if (state_q == S_CONV && cur[30:23] >= 8'd142) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        soc_q[i]     <= INIT_SOC;
        soc_out_q[i] <= '0;
      end
    end else begin
      if (state_q == S_IDLE && load) soc_q[load_cell] <= load_soc;
      // MAC: non-finite inputs leave the cell untouched
      if (state_q == S_MAC && !skip_q) soc_q[idx_q] <= soc_next;
      // PACK: republish this cell as float32
      if (state_q == S_PACK) soc_out_q[idx_q] <= fix_to_float(soc_q[idx_q]);
    end
  end

  // CONV: sample capture and float -> Q16.16 conversion of the current cell
  always_ff @(posedge clk) begin
    if (accept) cur_q <= '{i1, i2, i3, i4};
    if (state_q == S_CONV) begin
      fix_q  <= float_to_fix(cur);
      skip_q <= (cur[30:23] == 8'hFF);
    end
  end

endmodule

// File: tb/tb_soc_coulomb_counter.sv
// Directed bench for soc_coulomb_counter: scoreboard of expected SOC/err per sample,
// filled from a reference model when a sample is accepted, drained on out_valid.
module tb_soc_coulomb_counter;

  localparam logic [15:0] GAIN     = 16'h0100;
  localparam logic [31:0] INIT_SOC = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, load, out_valid, err;
  logic [31:0] i1, i2, i3, i4, load_soc, soc1, soc2, soc3, soc4;
  logic [1:0]  load_cell;

  typedef struct packed {
    logic             err;
    logic [3:0][31:0] soc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_soc [4];
  logic        m_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  soc_coulomb_counter #(.GAIN(GAIN), .INIT_SOC(INIT_SOC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4),
    .load(load), .load_cell(load_cell), .load_soc(load_soc),
    .soc1(soc1), .soc2(soc2), .soc3(soc3), .soc4(soc4),
    .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic longint m_conv(input logic [31:0] f, output bit sat);
    int     e;
    longint m, mag;
    e   = int'(f[30:23]);
    m   = longint'({1'b1, f[22:0]});
    sat = 1'b0;
    if (e == 0)           mag = 0;
    else if (e >= 165)    mag = 64'sh7FFFFFFF + 1;
    else if (e >= 134)    mag = m << (e - 134);
    else if (134 - e >= 40) mag = 0;
    else                  mag = m >> (134 - e);
    if (mag > 64'sh7FFFFFFF) begin
      sat = 1'b1;
      mag = 64'sh7FFFFFFF;
    end
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] m_pack(input logic [31:0] q);
    int          p;
    logic [31:0] mant;
    if (q == 32'd0) return 32'd0;
    p = 31;
    while (!q[p]) p--;
    if (p >= 23) mant = (q >> (p - 23)) & 32'h007FFFFF;
    else         mant = (q << (23 - p)) & 32'h007FFFFF;
    return {1'b0, 8'(p + 95), mant[22:0]};
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 4; c++) m_soc[c] = INIT_SOC;
    m_err = 1'b0;
    sb_q.delete();
  endtask

  task automatic m_sample(input logic [31:0] a, b, c, d);
    logic [31:0] cur [4];
    exp_t        ex;
    bit          sat;
    longint      fix, dl, ns;
    logic [31:0] d32;
    cur = '{a, b, c, d};
    for (int k = 0; k < 4; k++) begin
      if (cur[k][30:23] == 8'hFF) m_err = 1'b1;
      else begin
        fix = m_conv(cur[k], sat);
        if (sat) m_err = 1'b1;
        dl  = (fix * longint'(GAIN)) >>> 16;
        d32 = dl[31:0];
        ns  = longint'({32'd0, m_soc[k]}) - longint'($signed(d32));
        if (ns < 0) ns = 0;
        else if (ns > 64'sh00000000FFFFFFFF) ns = 64'sh00000000FFFFFFFF;
        m_soc[k] = ns[31:0];
      end
    end
    ex.err = m_err;
    for (int k = 0; k < 4; k++) ex.soc[k] = m_pack(m_soc[k]);
    sb_q.push_back(ex);
  endtask

  task automatic compare_exp(input string tag);
    exp_t ex;
    if (sb_q.size() == 0) chk({tag, "_scoreboard"}, 32'(sb_q.size()), 32'd1);
    else begin
      ex = sb_q.pop_front();
      chk({tag, "_soc1"}, soc1, ex.soc[0]);
      chk({tag, "_soc2"}, soc2, ex.soc[1]);
      chk({tag, "_soc3"}, soc3, ex.soc[2]);
      chk({tag, "_soc4"}, soc4, ex.soc[3]);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, ex.err});
    end
  endtask

  task automatic drive(input logic [31:0] a, b, c, d);
    i1 = a; i2 = b; i3 = c; i4 = d;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !in_ready; k++) step();
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    m_sample(a, b, c, d);
  endtask

  task automatic collect(input string tag, input int start_lat);
    int lat;
    lat = start_lat;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd13);
    compare_exp(tag);
    step();
    chk({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic do_load(input logic [1:0] c, input logic [31:0] v);
    load = 1'b1; load_cell = c; load_soc = v;
    step();
    load = 1'b0;
    m_soc[c] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; load = 1'b0;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    m_reset();
    chk("rst_soc1", soc1, 32'd0);
    chk("rst_soc4", soc4, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int nv;
    rst = 1'b1; in_valid = 1'b0; load = 1'b0; load_cell = 2'd0; load_soc = '0;
    i1 = '0; i2 = '0; i3 = '0; i4 = '0;
    do_reset();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // 1.0 A discharge on cell 0
    drive(32'h3F800000, 0, 0, 0);
    collect("t1", 1);
    chk("t1_soc1_ref", soc1, 32'h3EFFFFFE);
    chk("t1_soc2_ref", soc2, 32'h3F000000);

    // -2.0 A charge on cell 1
    do_reset();
    drive(0, 32'hC0000000, 0, 0);
    collect("t2", 1);
    chk("t2_soc2_ref", soc2, 32'h3F000002);
    chk("t2_err_ref", {31'd0, err}, 32'd0);

    // clamp at both ends, load without refresh
    do_reset();
    do_load(2'd0, 32'h00000100);
    drive(32'h40000000, 0, 0, 0);
    collect("t3a", 1);
    chk("t3a_soc1_ref", soc1, 32'h00000000);
    do_load(2'd3, 32'hFFFFFF00);
    chk("t3_load_no_refresh", soc4, 32'h3F000000);
    drive(0, 0, 0, 32'hBF800000);
    collect("t3b", 1);
    chk("t3b_soc4_ref", soc4, 32'h3F7FFFFF);

    // NaN hold and saturation, sticky err
    do_reset();
    drive(0, 0, 32'h7FC00000, 0);
    collect("t4a", 1);
    chk("t4a_soc3_ref", soc3, 32'h3F000000);
    chk("t4a_err_ref", {31'd0, err}, 32'd1);
    drive(32'h49742400, 0, 0, 0);
    collect("t4b", 1);
    chk("t4b_soc1_ref", soc1, 32'h3EFF0000);
    chk("t4b_err_sticky", {31'd0, err}, 32'd1);
    do_reset();

    // back-to-back with in_valid held high
    i1 = 32'h3F800000; i2 = 0; i3 = 0; i4 = 0;
    in_valid = 1'b1;
    step();
    m_sample(32'h3F800000, 0, 0, 0);
    for (int n = 1; n <= 13; n++) begin
      chk("t5_busy_in_ready", {31'd0, in_ready}, 32'd0);
      if (n < 13) step();
    end
    chk("t5_done_out_valid", {31'd0, out_valid}, 32'd1);
    compare_exp("t5a");
    step();
    chk("t5_rearm_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    m_sample(32'h3F800000, 0, 0, 0);
    collect("t5b", 1);

    // load during CONV is ignored
    drive(0, 0, 0, 0);
    load = 1'b1; load_cell = 2'd0; load_soc = 32'h0;
    step();
    load = 1'b0;
    collect("t5c", 2);

    // load and in_valid together: load first, sample next cycle
    i1 = 0; i2 = 0; i3 = 0; i4 = 0;
    in_valid = 1'b1; load = 1'b1; load_cell = 2'd1; load_soc = 32'h40000000;
    #1;
    chk("t5d_load_blocks", {31'd0, in_ready}, 32'd0);
    step();
    load = 1'b0;
    m_soc[1] = 32'h40000000;
    #1;
    chk("t5d_after_load", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    m_sample(0, 0, 0, 0);
    collect("t5d", 1);
    chk("t5d_soc2_ref", soc2, 32'h3E800000);

    // reset mid-operation aborts the sample
    do_reset();
    drive(32'h3F800000, 32'hBF800000, 0, 0);
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t6_rst_soc1", soc1, 32'd0);
    chk("t6_rst_soc2", soc2, 32'd0);
    chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    m_reset();
    #1;
    chk("t6_idle_in_ready", {31'd0, in_ready}, 32'd1);
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_valid) nv++;
    end
    chk("t6_no_out_valid", 32'(nv), 32'd0);
    drive(32'h3F800000, 0, 0, 0);
    collect("t6b", 1);
    chk("t6b_soc1_ref", soc1, 32'h3EFFFFFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
